// File: rtl/imx415_i2c_arbiter.sv
// imx415_i2c_arbiter
//   Shares one write-only uii2c master (4-byte transfers) between NUM_REQ
//   register-write requesters using a round-robin grant. Each requester
//   command {reg_addr[15:0], data[7:0]} is framed with DEV_ID into the 32-bit
//   uii2c write word {data, addr_lo, addr_hi, DEV_ID}.
//
//   Optional feature: define IIC_RETRY_EN to re-issue a failed command up to
//   MAX_RETRY times before reporting the error. Without it the first error is
//   reported immediately and no retry counter exists.
//
// Ports
//   I_clk, I_rst          clock, asynchronous active-high reset
//   I_req[NUM_REQ]        level request, held until own O_ack
//   I_cmd[NUM_REQ*24]     requester k at [24k+23:24k] = {addr, data}
//   O_ack / O_err         registered one-hot completion / failure pulse
//   O_iic_wr_data         to uii2c I_wr_data
//   O_iic_req             to uii2c I_iic_req
//   I_iic_busy            from uii2c O_iic_busy
//   I_iic_bus_error       from uii2c O_iic_bus_error
//   O_idle                high in IDLE with no request pending
`timescale 1ns/1ps
module imx415_i2c_arbiter #(
  parameter int          NUM_REQ      = 3,
  parameter logic [7:0]  DEV_ID       = 8'h34,
  parameter logic [19:0] BUSY_TIMEOUT = 20'd1000000,
  parameter int          MAX_RETRY    = 2
) (
  input  logic                  I_clk,
  input  logic                  I_rst,
  input  logic [NUM_REQ-1:0]    I_req,
  input  logic [NUM_REQ*24-1:0] I_cmd,
  output logic [NUM_REQ-1:0]    O_ack,
  output logic [NUM_REQ-1:0]    O_err,
  output logic [31:0]           O_iic_wr_data,
  output logic                  O_iic_req,
  input  logic                  I_iic_busy,
  input  logic                  I_iic_bus_error,
  output logic                  O_idle
);
  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_RETRY < 0) begin : g_bad_param
    $error("imx415_i2c_arbiter: NUM_REQ must be 2..8 and MAX_RETRY >= 0");
  end

  typedef enum logic [2:0] {
    ST_IDLE, ST_ISSUE, ST_WAIT_BUSY, ST_WAIT_DONE, ST_RESP
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [23:0]        cmd_q, cmd_d;
  logic               err_flag_q, err_flag_d;
  logic [19:0]        tmo_q, tmo_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  logic [31:0]        wr_data_q, wr_data_d;
  logic               iic_req_q, iic_req_d;

  logic [23:0]        cmd_arr [NUM_REQ];
  logic               found;
  logic [IDX_W-1:0]   pick;
  logic [NUM_REQ-1:0] grant_oh;
  logic               can_retry;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cmd
      assign cmd_arr[gi] = I_cmd[gi*24 +: 24];
    end
  endgenerate

`ifdef IIC_RETRY_EN
  localparam int RC_W = $clog2(MAX_RETRY + 2);
  logic [RC_W-1:0] retry_q, retry_d;
  assign can_retry = (int'(retry_q) < MAX_RETRY);
`else
  assign can_retry = 1'b0;
`endif

  assign grant_oh = NUM_REQ'(1) << grant_q;

  // Round-robin search: first set request strictly after the last grant.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_w;
    found  = 1'b0;
    pick   = rr_ptr_q;
    cand   = 0;
    cand_w = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_w = IDX_W'(cand);
      if (!found && I_req[cand_w]) begin
        found = 1'b1;
        pick  = cand_w;
      end
    end
  end

  always_comb begin
    logic finish;
    logic err_now;
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    cmd_d      = cmd_q;
    err_flag_d = err_flag_q;
    tmo_d      = tmo_q;
    ack_d      = '0;
    err_d      = '0;
    wr_data_d  = wr_data_q;
    iic_req_d  = iic_req_q;
    finish     = 1'b0;
    err_now    = err_flag_q;
`ifdef IIC_RETRY_EN
    retry_d    = retry_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_d  = pick;
          rr_ptr_d = pick;
          cmd_d    = cmd_arr[pick];
`ifdef IIC_RETRY_EN
          retry_d  = '0;
`endif
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Also covers a transfer left running by a reset: never overlap it.
        if (!I_iic_busy) begin
          iic_req_d = 1'b1;
          wr_data_d = {cmd_q[7:0], cmd_q[15:8], cmd_q[23:16], DEV_ID};
          tmo_d     = '0;
          state_d   = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (I_iic_busy) begin
          iic_req_d = 1'b0;
          state_d   = ST_WAIT_DONE;
        end else if (tmo_q == BUSY_TIMEOUT - 20'd1) begin
          iic_req_d = 1'b0;
          err_now   = 1'b1;
          finish    = 1'b1;
        end else begin
          tmo_d = tmo_q + 20'd1;
        end
      end
      ST_WAIT_DONE: begin
        err_now    = err_flag_q | I_iic_bus_error;
        err_flag_d = err_now;
        if (!I_iic_busy) finish = 1'b1;
      end
      ST_RESP: begin
        err_flag_d = 1'b0;
        if (err_flag_q && can_retry) begin
`ifdef IIC_RETRY_EN
          retry_d = retry_q + RC_W'(1);
`endif
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Ack is registered on entry to RESP so it is visible while in RESP,
    // letting the requester drop I_req before IDLE samples it again.
    if (finish) begin
      state_d    = ST_RESP;
      err_flag_d = err_now;
      if (!(err_now && can_retry)) begin
        ack_d = grant_oh;
        err_d = err_now ? grant_oh : '0;
      end
    end
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= IDX_W'(NUM_REQ - 1);
      grant_q    <= '0;
      cmd_q      <= '0;
      err_flag_q <= 1'b0;
      tmo_q      <= '0;
      ack_q      <= '0;
      err_q      <= '0;
      wr_data_q  <= '0;
      iic_req_q  <= 1'b0;
`ifdef IIC_RETRY_EN
      retry_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      cmd_q      <= cmd_d;
      err_flag_q <= err_flag_d;
      tmo_q      <= tmo_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      wr_data_q  <= wr_data_d;
      iic_req_q  <= iic_req_d;
`ifdef IIC_RETRY_EN
      retry_q    <= retry_d;
`endif
    end
  end

  assign O_ack         = ack_q;
  assign O_err         = err_q;
  assign O_iic_wr_data = wr_data_q;
  assign O_iic_req     = iic_req_q;
  assign O_idle        = (state_q == ST_IDLE) && (I_req == '0);

endmodule

// File: tb/tb_imx415_i2c_arbiter.sv
`timescale 1ns/1ps
module tb_imx415_i2c_arbiter;
  localparam int         N    = 3;
  localparam logic [7:0] DEV  = 8'h34;
  localparam int         TMO  = 16;
  localparam int         MAXR = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*24-1:0] cmd;
  logic [N-1:0]    ack, err;
  logic [31:0]     wr;
  logic            iic_req, busy, bus_err, idle;

  always #5 clk = ~clk;

  imx415_i2c_arbiter #(
    .NUM_REQ(N), .DEV_ID(DEV), .BUSY_TIMEOUT(20'(TMO)), .MAX_RETRY(MAXR)
  ) dut (
    .I_clk(clk), .I_rst(rst), .I_req(req), .I_cmd(cmd),
    .O_ack(ack), .O_err(err), .O_iic_wr_data(wr), .O_iic_req(iic_req),
    .I_iic_busy(busy), .I_iic_bus_error(bus_err), .O_idle(idle)
  );

  int total = 0;
  int bad   = 0;

  // uii2c model configuration and records
  int          busy_min = 2, busy_max = 2, dly_max = 0;
  bit          no_busy = 1'b0;
  bit          err_plan[$];
  logic [31:0] hs_q[$];

  // requesters: pend[k][0] is the command currently presented
  logic [23:0]  pend [N][$];
  int           start_cnt = 0;
  logic [N-1:0] ack_vec_q[$];
  logic [N-1:0] err_vec_q[$];

  // reference model outputs
  int          rr_model = N - 1;
  int          exp_idx[$];
  logic [31:0] exp_wr[$];
  bit          exp_err[$];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // uii2c: accept a request, optional delay, busy for a random length,
  // optional one-cycle bus error in the middle of busy.
  initial begin
    busy = 1'b0; bus_err = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!no_busy && iic_req === 1'b1 && !busy) begin
        int d, len;
        bit e;
        hs_q.push_back(wr);
        e   = (err_plan.size() > 0) ? err_plan.pop_front() : 1'b0;
        d   = int'($urandom_range(dly_max, 0));
        len = int'($urandom_range(busy_max, busy_min));
        repeat (d) begin @(posedge clk); #1; end
        busy = 1'b1;
        for (int c = 0; c < len; c++) begin
          bus_err = e && (c == len / 2);
          @(posedge clk); #1;
        end
        bus_err = 1'b0;
        busy    = 1'b0;
      end
    end
  end

  // Requester side: records acks, moves to next command or drops request.
  initial begin
    int seen;
    seen = 0;
    req  = '0;
    cmd  = '0;
    forever begin
      @(posedge clk); #2;
      if (ack !== '0) begin
        $display("[%0t] xfer ack=%b err=%b wr_data=%h", $time, ack, err, wr);
        ack_vec_q.push_back(ack);
        err_vec_q.push_back(err);
        for (int k = 0; k < N; k++) begin
          if (ack[k] === 1'b1) begin
            if (pend[k].size() > 0) void'(pend[k].pop_front());
            if (pend[k].size() > 0) cmd[k*24 +: 24] = pend[k][0];
            else req[k] = 1'b0;
          end
        end
      end
      if (start_cnt != seen) begin
        seen = start_cnt;
        for (int k = 0; k < N; k++) begin
          if (pend[k].size() > 0) begin
            cmd[k*24 +: 24] = pend[k][0];
            req[k] = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic kick();
    start_cnt++;
  endtask

  task automatic clear_records();
    hs_q.delete();
    ack_vec_q.delete();
    err_vec_q.delete();
    err_plan.delete();
    exp_err.delete();
  endtask

  // Round-robin reference: every requester with commands left stays pending,
  // so each grant goes to the next requester after the previous grant that
  // still has work.
  task automatic rr_predict(input int start_ptr);
    logic [23:0] work [N][$];
    int ptr, left;
    exp_idx.delete();
    exp_wr.delete();
    left = 0;
    for (int k = 0; k < N; k++) begin
      work[k] = pend[k];
      left += pend[k].size();
    end
    ptr = start_ptr;
    while (left > 0) begin
      for (int i = 1; i <= N; i++) begin
        int c;
        c = (ptr + i) % N;
        if (work[c].size() > 0) begin
          logic [23:0] w;
          w = work[c].pop_front();
          exp_idx.push_back(c);
          exp_wr.push_back({w[7:0], w[15:8], w[23:16], DEV});
          ptr = c;
          left--;
          break;
        end
      end
    end
    rr_model = ptr;
  endtask

  task automatic wait_acks(input int n, output int got);
    int c;
    c = 0;
    while (ack_vec_q.size() < n && c < 4000) begin tick(); c++; end
    repeat (4) tick();
    got = ack_vec_q.size();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    total++; if (wr !== 32'h0) begin bad++; $display("FAIL reset_wr_data got=%h want=0", wr); end
    rst = 1'b0;
    tick();
    total++; if (ack !== '0) begin bad++; $display("FAIL reset_ack got=%b want=0", ack); end
    total++; if (err !== '0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
    total++; if (iic_req !== 1'b0) begin bad++; $display("FAIL reset_iic_req got=%b want=0", iic_req); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b want=1", idle); end
  endtask

  task automatic test_round_robin();
    int got;
    clear_records();
    busy_min = 3; busy_max = 8; dly_max = 2;
    for (int k = 0; k < N; k++) repeat (2) pend[k].push_back(24'($urandom));
    rr_predict(rr_model);
    kick();
    wait_acks(exp_idx.size(), got);
    total++; if (got != exp_idx.size()) begin bad++; $display("FAIL rr_count got=%0d want=%0d", got, exp_idx.size()); end
    for (int i = 0; i < got && i < exp_idx.size(); i++) begin
      total++;
      if (ack_vec_q[i] !== (N'(1) << exp_idx[i])) begin bad++; $display("FAIL rr_ack[%0d] got=%b want=%b", i, ack_vec_q[i], N'(1) << exp_idx[i]); end
      total++;
      if (err_vec_q[i] !== '0) begin bad++; $display("FAIL rr_err[%0d] got=%b want=0", i, err_vec_q[i]); end
      total++;
      if (i >= hs_q.size() || hs_q[i] !== exp_wr[i]) begin bad++; $display("FAIL rr_wr[%0d] got=%h want=%h", i, (i < hs_q.size()) ? hs_q[i] : 32'hx, exp_wr[i]); end
    end
  endtask

  task automatic test_single_write();
    int got;
    clear_records();
    busy_min = 50; busy_max = 50; dly_max = 0;
    pend[0].push_back(24'h300000);
    rr_predict(rr_model);
    kick();
    tick();
    total++; if (iic_req !== 1'b0) begin bad++; $display("FAIL single_latency1 got=%b want=0", iic_req); end
    tick();
    total++; if (iic_req !== 1'b1) begin bad++; $display("FAIL single_latency2 got=%b want=1", iic_req); end
    total++; if (wr !== 32'h00003034) begin bad++; $display("FAIL single_wr got=%h want=00003034", wr); end
    wait_acks(1, got);
    total++; if (got != 1) begin bad++; $display("FAIL single_ack_count got=%0d want=1", got); end
    total++; if (hs_q.size() != 1) begin bad++; $display("FAIL single_handshakes got=%0d want=1", hs_q.size()); end
    if (got > 0) begin
      total++; if (ack_vec_q[0] !== 3'b001) begin bad++; $display("FAIL single_ack got=%b want=001", ack_vec_q[0]); end
      total++; if (err_vec_q[0] !== 3'b000) begin bad++; $display("FAIL single_err got=%b want=000", err_vec_q[0]); end
    end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL single_idle got=%b want=1", idle); end
  endtask

`ifndef IIC_RETRY_EN
  task automatic test_bus_error();
    int got;
    clear_records();
    busy_min = 4; busy_max = 8; dly_max = 1;
    pend[2].push_back(24'($urandom));
    pend[2].push_back(24'($urandom));
    err_plan.push_back(1'b1);
    err_plan.push_back(1'b0);
    exp_err = err_plan;
    rr_predict(rr_model);
    kick();
    wait_acks(2, got);
    total++; if (got != 2) begin bad++; $display("FAIL buserr_count got=%0d want=2", got); end
    for (int i = 0; i < got && i < 2; i++) begin
      total++;
      if (ack_vec_q[i] !== 3'b100) begin bad++; $display("FAIL buserr_ack[%0d] got=%b want=100", i, ack_vec_q[i]); end
      total++;
      if (err_vec_q[i] !== (exp_err[i] ? 3'b100 : 3'b000)) begin bad++; $display("FAIL buserr_err[%0d] got=%b want=%b", i, err_vec_q[i], exp_err[i] ? 3'b100 : 3'b000); end
      total++;
      if (i >= hs_q.size() || hs_q[i] !== exp_wr[i]) begin bad++; $display("FAIL buserr_wr[%0d] want=%h", i, exp_wr[i]); end
    end
  endtask

  task automatic test_timeout();
    int c, n, got;
    clear_records();
    no_busy = 1'b1;
    pend[1].push_back(24'($urandom));
    rr_predict(rr_model);
    kick();
    c = 0;
    while (iic_req !== 1'b1 && c < 20) begin tick(); c++; end
    n = 0;
    while (iic_req === 1'b1 && n < 100) begin tick(); n++; end
    total++; if (n != TMO) begin bad++; $display("FAIL timeout_req_cycles got=%0d want=%0d", n, TMO); end
    total++; if (ack !== 3'b010) begin bad++; $display("FAIL timeout_ack got=%b want=010", ack); end
    total++; if (err !== 3'b010) begin bad++; $display("FAIL timeout_err got=%b want=010", err); end
    total++; if (wr !== exp_wr[0]) begin bad++; $display("FAIL timeout_wr got=%h want=%h", wr, exp_wr[0]); end
    wait_acks(1, got);
    no_busy = 1'b0;
    total++; if (got != 1) begin bad++; $display("FAIL timeout_ack_count got=%0d want=1", got); end
  endtask
`endif

  task automatic test_random();
    int got, cnt;
    for (int r = 0; r < 4; r++) begin
      clear_records();
      busy_min = 2; busy_max = 10; dly_max = 3;
      cnt = 0;
      for (int k = 0; k < N; k++) begin
        int m;
        m = int'($urandom_range(3, 0));
        repeat (m) pend[k].push_back(24'($urandom));
        cnt += m;
      end
      if (cnt == 0) begin pend[r % N].push_back(24'($urandom)); cnt = 1; end
      for (int i = 0; i < cnt; i++) begin
`ifdef IIC_RETRY_EN
        err_plan.push_back(1'b0);
`else
        err_plan.push_back($urandom_range(3, 0) == 0);
`endif
      end
      exp_err = err_plan;
      rr_predict(rr_model);
      kick();
      wait_acks(cnt, got);
      total++; if (got != cnt) begin bad++; $display("FAIL rand%0d_count got=%0d want=%0d", r, got, cnt); end
      for (int i = 0; i < got && i < cnt; i++) begin
        logic [N-1:0] oh;
        oh = N'(1) << exp_idx[i];
        total++;
        if (ack_vec_q[i] !== oh) begin bad++; $display("FAIL rand%0d_ack[%0d] got=%b want=%b", r, i, ack_vec_q[i], oh); end
        total++;
        if (err_vec_q[i] !== (exp_err[i] ? oh : '0)) begin bad++; $display("FAIL rand%0d_err[%0d] got=%b want=%b", r, i, err_vec_q[i], exp_err[i] ? oh : '0); end
        total++;
        if (i >= hs_q.size() || hs_q[i] !== exp_wr[i]) begin bad++; $display("FAIL rand%0d_wr[%0d] want=%h", r, i, exp_wr[i]); end
      end
    end
  endtask

`ifdef IIC_RETRY_EN
  task automatic test_retry();
    int got;
    for (int p = 0; p < 2; p++) begin
      clear_records();
      busy_min = 3; busy_max = 5; dly_max = 1;
      pend[0].push_back(24'($urandom));
      err_plan.push_back(1'b1);
      err_plan.push_back(1'b1);
      err_plan.push_back(p == 1);
      rr_predict(rr_model);
      kick();
      wait_acks(1, got);
      total++; if (got != 1) begin bad++; $display("FAIL retry%0d_ack_count got=%0d want=1", p, got); end
      total++; if (hs_q.size() != MAXR + 1) begin bad++; $display("FAIL retry%0d_handshakes got=%0d want=%0d", p, hs_q.size(), MAXR + 1); end
      for (int i = 0; i < hs_q.size(); i++) begin
        total++;
        if (hs_q[i] !== exp_wr[0]) begin bad++; $display("FAIL retry%0d_wr[%0d] got=%h want=%h", p, i, hs_q[i], exp_wr[0]); end
      end
      if (got > 0) begin
        total++;
        if (err_vec_q[0] !== ((p == 1) ? 3'b001 : 3'b000)) begin bad++; $display("FAIL retry%0d_err got=%b want=%b", p, err_vec_q[0], (p == 1) ? 3'b001 : 3'b000); end
      end
    end
  endtask
`endif

  task automatic test_reset_mid();
    int c, viol, got, base;
    clear_records();
    busy_min = 40; busy_max = 40; dly_max = 0;
    pend[0].push_back(24'($urandom));
    rr_predict(rr_model);
    kick();
    c = 0;
    while (hs_q.size() < 1 && c < 50) begin tick(); c++; end
    repeat (3) tick();
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_setup_busy got=%b want=1", busy); end
    total++; if (iic_req !== 1'b0) begin bad++; $display("FAIL rstmid_iic_req got=%b want=0", iic_req); end
    total++; if (wr !== 32'h0) begin bad++; $display("FAIL rstmid_wr got=%h want=0", wr); end
    total++; if (ack !== '0 || err !== '0) begin bad++; $display("FAIL rstmid_ack_err got=%b/%b want=0/0", ack, err); end
    tick();
    pend[1].push_back(24'($urandom));
    pend[2].push_back(24'($urandom));
    kick();
    tick();
    rst = 1'b0;
    base = hs_q.size();
    rr_predict(N - 1);
    viol = 0;
    c = 0;
    while (busy === 1'b1 && c < 100) begin
      if (iic_req !== 1'b0) viol++;
      tick();
      c++;
    end
    total++; if (viol != 0) begin bad++; $display("FAIL rstmid_req_while_busy got=%0d want=0", viol); end
    wait_acks(3, got);
    total++; if (got != 3) begin bad++; $display("FAIL rstmid_ack_count got=%0d want=3", got); end
    for (int i = 0; i < got && i < 3; i++) begin
      total++;
      if (ack_vec_q[i] !== (N'(1) << exp_idx[i])) begin bad++; $display("FAIL rstmid_ack[%0d] got=%b want=%b", i, ack_vec_q[i], N'(1) << exp_idx[i]); end
      total++;
      if (base + i >= hs_q.size() || hs_q[base + i] !== exp_wr[i]) begin bad++; $display("FAIL rstmid_wr[%0d] want=%h", i, exp_wr[i]); end
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_round_robin();
    test_single_write();
`ifndef IIC_RETRY_EN
    test_bus_error();
    test_timeout();
`endif
    test_random();
`ifdef IIC_RETRY_EN
    test_retry();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imx415_i2c_arbiter.md
Name: imx415_i2c_arbiter

Overview:
- Shares one uii2c master (write-only, 4-byte transfers) between NUM_REQ independent register-write requesters, e.g. init table loader, stream start/stop, AE gain/shutter updater.
- Round-robin grant; each command is one 24-bit {reg_addr[15:0], data[7:0]} word, framed with DEV_ID into the 32-bit uii2c write word.
- Sits between the sensor config sequencers and uii2c; returns a per-requester ack/err pulse.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- DEV_ID, 8'h34, sensor I2C write address placed in byte 0.
- BUSY_TIMEOUT, 20'd1000000, max cycles in WAIT_BUSY for uii2c to raise busy before the command is failed.
- MAX_RETRY, 2, re-issue count on error (used only with IIC_RETRY_EN).

Ports:
- I_clk, in, 1: system clock.
- I_rst, in, 1: asynchronous, active-high reset.
- I_req, in, NUM_REQ: level request; held high until own O_ack.
- I_cmd, in, NUM_REQ*24: requester k at bits [24k+23:24k] = {addr[15:0], data[7:0]}; stable while I_req[k] high.
- O_ack, out, NUM_REQ: one-cycle completion pulse to the granted requester.
- O_err, out, NUM_REQ: asserted in the same cycle as O_ack when the transfer failed.
- O_iic_wr_data, out, 32: to uii2c I_wr_data.
- O_iic_req, out, 1: to uii2c I_iic_req.
- I_iic_busy, in, 1: from uii2c O_iic_busy.
- I_iic_bus_error, in, 1: from uii2c O_iic_bus_error.
- O_idle, out, 1: high in IDLE with no request pending.

Behaviour:
- Reset (async, any state including mid-transfer): state=IDLE, O_ack=0, O_err=0, O_iic_req=0, O_iic_wr_data=0, O_idle=1, rr_ptr=NUM_REQ-1 so requester 0 wins first, err_flag=0, timeout counter=0, retry counter=0.
- Mid-transfer reset does not abort uii2c; after reset, ISSUE waits for I_iic_busy=0 before a new request.
- IDLE:
  - If I_req!=0, grant the first set bit searching upward from rr_ptr+1 (mod NUM_REQ).
  - Latch grant index and its I_cmd; rr_ptr<=grant; go to ISSUE.
- ISSUE:
  - Wait for I_iic_busy=0.
  - Then O_iic_req<=1 and O_iic_wr_data<={data, addr[7:0], addr[15:8], DEV_ID}, i.e. [7:0]=DEV_ID, [15:8]=addr high, [23:16]=addr low, [31:24]=data.
  - Clear timeout counter; go to WAIT_BUSY.
- WAIT_BUSY:
  - If I_iic_busy=1, O_iic_req<=0 and go to WAIT_DONE.
  - Otherwise, when the counter reaches BUSY_TIMEOUT-1: O_iic_req<=0, err_flag<=1, go to RESP.
- WAIT_DONE:
  - err_flag |= I_iic_bus_error each cycle (sticky).
  - On I_iic_busy=0, go to RESP.
- RESP:
  - One cycle: O_ack[grant]=1 and O_err[grant]=err_flag; clear err_flag; return to IDLE.
  - Requester deasserts I_req, or presents its next command, in the cycle after ack.
- Latency and throughput:
  - I_req rise in IDLE to O_iic_req high: 2 clocks when uii2c is idle.
  - Arbiter overhead per command: 3 clocks plus the uii2c transfer.
- Fairness and stability:
  - A requester that holds I_req continuously is served at most once per round while others are pending.
  - A request arriving during a grant waits; the grant is never preempted.
  - I_req changes of non-granted requesters during a transfer have no effect.
- O_ack/O_err are registered one-hot; never more than one bit set.

Optional Feature:
- IIC_RETRY_EN defined: on error in RESP (bus error or timeout), if retry_cnt<MAX_RETRY, then retry_cnt++, clear err_flag, return to ISSUE with the latched command and no ack. Otherwise ack with O_err=1. retry_cnt clears on each new grant.
- Not defined: the first error is reported immediately; MAX_RETRY is ignored; no retry counter is synthesized.

Test Plan:
- Single write: I_req=3'b001, I_cmd[23:0]=24'h3000_00, model busy for 50 cycles -> O_iic_wr_data=32'h00_00_30_34, one O_iic_req handshake, O_ack=3'b001 pulse, O_err=0.
- Round-robin: all three requesters held high for 6 commands -> grant order 0,1,2,0,1,2; exactly one ack bit per transfer.
- Bus error: I_iic_bus_error pulsed during busy for requester 2 (macro off) -> O_ack=3'b100 with O_err=3'b100 in the same cycle, next command clean.
- Timeout: busy never asserted, BUSY_TIMEOUT=16 -> O_iic_req drops after 16 cycles, O_ack and O_err pulse together.
- Retry (IIC_RETRY_EN, MAX_RETRY=2): errors on the first 2 attempts, third clean -> 3 O_iic_req handshakes with identical wr_data, a single O_ack, O_err=0. Errors on all 3 attempts -> O_err=1.
- Reset mid-transfer: assert I_rst while in WAIT_DONE with busy high -> outputs zero immediately; after release, no O_iic_req until busy drops; requester 0 granted first.
